// File: rtl/dwn_pkg.sv
// ----------------------------------------------------------------------------
// dwn_pkg
// Shared types for the DWN datapath blocks.
//   skid_state_t : occupancy of a 2-entry skid buffer
//                  (SKID_EMPTY = 0 beats, SKID_HALF = 1 beat, SKID_FULL = 2 beats)
// ----------------------------------------------------------------------------
package dwn_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_HALF,
        SKID_FULL
    } skid_state_t;

endpackage

// File: rtl/fixed_dwn_skid_buffer.sv
// ----------------------------------------------------------------------------
// fixed_dwn_skid_buffer
// Generic 2-entry skid buffer on a flat vector.
// Moves one beat per cycle at full throughput.
// Output valid/data and input ready all come straight from registers, so
// no combinational path exists between the upstream and downstream handshakes.
//
// Parameters
//   DATA_WIDTH     width of one beat
// Ports
//   clk            clock, rising edge
//   rst            asynchronous reset, active-low
//   data_in        beat from upstream
//   data_in_valid  upstream beat valid
//   data_in_ready  registered; buffer can accept a beat this cycle
//   data_out       head-of-line beat (the main register)
//   data_out_valid registered; data_out holds a beat
//   data_out_ready downstream accepts data_out this cycle
// ----------------------------------------------------------------------------
module fixed_dwn_skid_buffer
    import dwn_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready
);

    skid_state_t           state_q;
    skid_state_t           state_d;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] main_d;
    logic [DATA_WIDTH-1:0] skid_q;
    logic [DATA_WIDTH-1:0] skid_d;
    logic                  valid_q;
    logic                  ready_q;
    logic                  in_fire;
    logic                  out_fire;

    // The handshakes use the registered ready/valid only, which keeps the
    // upstream and downstream sides timing-isolated from each other.
    assign in_fire  = data_in_valid & ready_q;
    assign out_fire = valid_q & data_out_ready;

    // The main register is always the head of the line; the skid register only
    // catches the beat accepted in the cycle the downstream stalled.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            SKID_EMPTY: begin
                if (in_fire) begin
                    state_d = SKID_HALF;
                    main_d  = data_in;
                end
            end
            SKID_HALF: begin
                if (in_fire && !out_fire) begin
                    state_d = SKID_FULL;
                    skid_d  = data_in;
                end else if (!in_fire && out_fire) begin
                    state_d = SKID_EMPTY;
                end else if (in_fire && out_fire) begin
                    state_d = SKID_HALF;
                    main_d  = data_in;
                end
            end
            SKID_FULL: begin
                // ready is low here, so only the drain side can move
                if (out_fire) begin
                    state_d = SKID_HALF;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = SKID_EMPTY;
            end
        endcase
    end

    // valid and ready are registered from the next state so that both are
    // correct in the same cycle that the state takes effect. Reset holds
    // ready low, and ready rises on the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SKID_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            valid_q <= (state_d != SKID_EMPTY);
            ready_q <= (state_d != SKID_FULL);
        end
    end

    assign data_out       = main_q;
    assign data_out_valid = valid_q;
    assign data_in_ready  = ready_q;

endmodule

// File: rtl/fixed_dwn_unflatten.sv
// ----------------------------------------------------------------------------
// fixed_dwn_unflatten
// Inverse of the DWN flatten stage. Takes a flat LUT-layer bit vector and
// re-forms it as a row-major 2D array, OUT_ROWS rows of OUT_COLS bits each:
//   data_out_0[i][j] = data_in_0[i*OUT_COLS + j]
// A registered 2-entry skid buffer sits in the path. It gives full
// throughput and leaves no combinational path between stages.
//
// Parameters
//   OUT_COLS          bits per output row
//   OUT_ROWS          number of output rows (flat width W = OUT_COLS*OUT_ROWS)
// Ports
//   clk               clock, rising edge
//   rst               asynchronous reset, active-low
//   data_in_0         flat input vector, W bits
//   data_in_0_valid   input beat valid
//   data_in_0_ready   registered; block can accept a beat
//   data_out_0        unpacked 2D output, [OUT_COLS-1:0] x [0:OUT_ROWS-1]
//   data_out_0_valid  registered output valid
//   data_out_0_ready  downstream accepts
// ----------------------------------------------------------------------------
module fixed_dwn_unflatten #(
    parameter int OUT_COLS = 2,
    parameter int OUT_ROWS = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [OUT_COLS*OUT_ROWS-1:0]     data_in_0,
    input  logic                             data_in_0_valid,
    output logic                             data_in_0_ready,
    output logic [OUT_COLS-1:0]              data_out_0 [0:OUT_ROWS-1],
    output logic                             data_out_0_valid,
    input  logic                             data_out_0_ready
);

    localparam int W = OUT_COLS * OUT_ROWS;

    logic [W-1:0] remapped;
    logic [W-1:0] buffered;

    // The remap happens before the registers. Row i, column j goes into
    // the slot i*OUT_COLS + j of the buffered vector. Each output row is then
    // one contiguous slice, and the buffer stays a generic flat vector.
    for (genvar i = 0; i < OUT_ROWS; i++) begin : g_row_in
        for (genvar j = 0; j < OUT_COLS; j++) begin : g_col_in
            assign remapped[i*OUT_COLS + j] = data_in_0[i*OUT_COLS + j];
        end
    end

    fixed_dwn_skid_buffer #(
        .DATA_WIDTH (W)
    ) u_skid (
        .clk            (clk),
        .rst            (rst),
        .data_in        (remapped),
        .data_in_valid  (data_in_0_valid),
        .data_in_ready  (data_in_0_ready),
        .data_out       (buffered),
        .data_out_valid (data_out_0_valid),
        .data_out_ready (data_out_0_ready)
    );

    for (genvar i = 0; i < OUT_ROWS; i++) begin : g_row_out
        assign data_out_0[i] = buffered[i*OUT_COLS +: OUT_COLS];
    end

endmodule
